// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// digit glyphs (bit order gfedcba) and the converter FSM state type.
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F));
  localparam logic [6:0] GLYPH_1 = 7'((1 << SEG_B) | (1 << SEG_C));
  localparam logic [6:0] GLYPH_2 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_G));
  localparam logic [6:0] GLYPH_3 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_G));
  localparam logic [6:0] GLYPH_4 = 7'((1 << SEG_B) | (1 << SEG_C) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] GLYPH_5 = 7'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] GLYPH_6 = 7'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] GLYPH_7 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C));
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] GLYPH_DASH  = 7'(1 << SEG_G);
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with valid/ready input and sticky
// overflow detection when the value needs more than NUM_DIGITS digits.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W    = 16,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow_acc,
  output logic                    commit,
  output conv_state_t             state
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + VALUE_W;
  localparam int CNT_W = $clog2(VALUE_W);

  // Handshake: a value transfers on a rising edge where value_valid and
  // value_ready are both high; value_ready is high exactly while IDLE, and
  // offers made while it is low are dropped rather than held.
  conv_state_t      state_q, state_d;
  logic [SR_W-1:0]  sr_q, adjusted;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (value_valid) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adjusted = sr_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr_q[VALUE_W + 4*i +: 4] >= 4'd5)
        adjusted[VALUE_W + 4*i +: 4] = sr_q[VALUE_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (value_valid) begin
          sr_q  <= {{BCD_W{1'b0}}, value};
          cnt_q <= '0;
          ovf_q <= 1'b0;
        end
        CONVERT: begin
          sr_q  <= {adjusted[SR_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          // A carry out of the top digit means the value has no room in NUM_DIGITS
          ovf_q <= ovf_q | adjusted[SR_W-1];
        end
        default: ;
      endcase
    end
  end

  assign value_ready  = (state_q == IDLE);
  assign commit       = (state_q == COMMIT);
  assign bcd          = sr_q[SR_W-1 -: BCD_W];
  assign overflow_acc = ovf_q;
  assign state        = state_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment driver: binary-to-BCD conversion, committed display
// register, refresh scan and glyph decode. Option: LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W        = 16,
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  done,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [7:0]            seg,
  output conv_state_t           fsm_state
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [BCD_W-1:0] bcd, display_q;
  logic             ovf_acc, commit;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clock        (clock),
    .rst_n        (rst_n),
    .value        (value),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .bcd          (bcd),
    .overflow_acc (ovf_acc),
    .commit       (commit),
    .state        (fsm_state)
  );

  // Digits only change on commit, so the scan never shows a half-converted value
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= commit;
      if (commit) begin
        display_q <= bcd;
        overflow  <= ovf_acc;
      end
    end
  end

  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  logic blank_digit;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;

  // Digit i is blank when it and every digit above it are zero; digit 0 never is
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero & (display_q[4*i +: 4] == 4'd0);
      lz_blank[i] = upper_zero;
    end
    blank_digit = lz_blank[idx_q];
  end
`else
  assign blank_digit = 1'b0;
`endif

  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] sel_raw;

  always_comb begin
    nibble = display_q[{idx_q, 2'b00} +: 4];
    if (overflow)         glyph = GLYPH_DASH;
    else if (blank_digit) glyph = GLYPH_BLANK;
    else                  glyph = digit_glyph(nibble);
    seg_raw         = 8'h00;
    seg_raw[6:0]    = glyph;
    seg_raw[SEG_DP] = dp_mask[idx_q];
    sel_raw         = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sel <= SEL_OFF;
      seg <= SEG_OFF;
    end else begin
      sel <= sel_raw ^ SEL_OFF;
      seg <= seg_raw ^ SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 6-digit and a 4-digit instance, directed
// values, expected digit patterns queued at offer time and checked on done.
module tb_seven_seg_scan_driver;
  import seven_seg_pkg::*;

  localparam int DIV = 4;
  localparam int W   = 49;  // {overflow, digit5 .. digit0}, each digit {dp,g..a} active-high
  localparam int CONV_LAT = 17;  // edges from the accept edge until done is seen

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [47:0] D_1234 = 48'h0000_065B_4F66;
  localparam logic [47:0] D_5678 = 48'h0000_6D7D_077F;
  localparam logic [47:0] D_42   = 48'h0000_0000_665B;
  localparam logic [47:0] D_7DP2 = 48'h0000_0080_0007;
  localparam logic [47:0] D_0    = 48'h0000_0000_003F;
  localparam logic [47:0] D_321  = 48'h0000_004F_5B06;
`else
  localparam logic [47:0] D_1234 = 48'h3F3F_065B_4F66;
  localparam logic [47:0] D_5678 = 48'h3F3F_6D7D_077F;
  localparam logic [47:0] D_42   = 48'h0000_3F3F_665B;
  localparam logic [47:0] D_7DP2 = 48'h3F3F_3FBF_3F07;
  localparam logic [47:0] D_0    = 48'h3F3F_3F3F_3F3F;
  localparam logic [47:0] D_321  = 48'h3F3F_3F4F_5B06;
`endif
  localparam logic [47:0] D_DASH4 = 48'h0000_4040_4040;

  // clock / reset
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] value6, value4;
  logic        valid6, valid4, ready6, ready4, done6, done4, ovf6, ovf4;
  logic [5:0]  dp6, sel6;
  logic [3:0]  dp4, sel4;
  logic [7:0]  seg6, seg4;
  conv_state_t st6, st4;

  seven_seg_scan_driver #(.VALUE_W(16), .NUM_DIGITS(6), .REFRESH_DIV(DIV),
                          .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut6 (
    .clock(clock), .rst_n(rst_n), .value(value6), .value_valid(valid6),
    .value_ready(ready6), .dp_mask(dp6), .done(done6), .overflow(ovf6),
    .sel(sel6), .seg(seg6), .fsm_state(st6));

  seven_seg_scan_driver #(.VALUE_W(16), .NUM_DIGITS(4), .REFRESH_DIV(DIV),
                          .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut4 (
    .clock(clock), .rst_n(rst_n), .value(value4), .value_valid(valid4),
    .value_ready(ready4), .dp_mask(dp4), .done(done4), .overflow(ovf4),
    .sel(sel4), .seg(seg4), .fsm_state(st4));

  logic [W-1:0] exp6_q[$];
  logic [W-1:0] exp4_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? ready6 : ready4;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done6 : done4;
  endfunction

  // Watch one full scan and record the active-high pattern shown on each digit
  task automatic capture(input int inst, output logic [47:0] segs, output logic [5:0] seen);
    logic [5:0] s;
    logic [7:0] g;
    segs = '0;
    seen = '0;
    repeat (6*DIV + 4) begin
      @(negedge clock);
      if (inst == 0) begin s = ~sel6; g = ~seg6; end
      else begin s = {2'b00, ~sel4}; g = ~seg4; end
      for (int i = 0; i < 6; i++)
        if (s[i]) begin segs[8*i +: 8] = g; seen[i] = 1'b1; end
    end
  endtask

  // driver: offer a value, optionally poke a second value while busy
  task automatic offer(input int inst, input logic [15:0] v, input logic [W-1:0] exp,
                       input bit ghost, input logic [15:0] gv);
    int cnt;
    int waited;
    waited = 0;
    @(negedge clock);
    while (!get_ready(inst) && waited < 100) begin @(negedge clock); waited++; end
    if (waited >= 100) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    if (inst == 0) begin exp6_q.push_back(exp); value6 = v; valid6 = 1'b1; end
    else           begin exp4_q.push_back(exp); value4 = v; valid4 = 1'b1; end
    @(posedge clock);
    @(negedge clock);
    if (inst == 0) begin valid6 = 1'b0; value6 = ~v; end
    else           begin valid4 = 1'b0; value4 = ~v; end
    cnt = 0;
    while (!get_done(inst) && cnt < 40) begin
      if (ghost && cnt == 2) begin
        if (inst == 0) begin value6 = gv; valid6 = 1'b1; end
        else           begin value4 = gv; valid4 = 1'b1; end
      end
      if (ghost && cnt == 6) begin valid6 = 1'b0; valid4 = 1'b0; end
      @(negedge clock);
      cnt++;
    end
    check("done_latency", cnt, CONV_LAT);
    repeat (6*DIV + 8) @(negedge clock);
  endtask

  // scoreboard monitors: one per instance, triggered by done
  initial begin : mon6
    logic [W-1:0] e;
    logic [47:0]  segs;
    logic [5:0]   seen;
    logic         ov;
    forever begin
      @(negedge clock);
      if (rst_n && done6) begin
        ov = ovf6;
        if (exp6_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon6_unexpected_done: got done=1 expected no commit");
        end else begin
          e = exp6_q.pop_front();
          capture(0, segs, seen);
          check("mon6_digits_seen", seen, 6'h3F);
          check("mon6_display", {ov, segs}, e);
        end
      end
    end
  end

  initial begin : mon4
    logic [W-1:0] e;
    logic [47:0]  segs;
    logic [5:0]   seen;
    logic         ov;
    forever begin
      @(negedge clock);
      if (rst_n && done4) begin
        ov = ovf4;
        if (exp4_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon4_unexpected_done: got done=1 expected no commit");
        end else begin
          e = exp4_q.pop_front();
          capture(1, segs, seen);
          check("mon4_digits_seen", seen, 6'h0F);
          check("mon4_display", {ov, segs}, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [5:0]  exp_sel;
    logic [47:0] segs;
    logic [5:0]  seen;
    valid6 = 1'b0; valid4 = 1'b0; value6 = '0; value4 = '0; dp6 = '0; dp4 = '0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ready6", ready6, 1'b1);
    check("reset_done6", done6, 1'b0);
    check("reset_ovf6", ovf6, 1'b0);
    check("reset_sel6", sel6, 6'h3F);
    check("reset_seg6", seg6, 8'hFF);
    check("reset_state6", st6, IDLE);
    check("reset_sel4", sel4, 4'hF);
    check("reset_ready4", ready4, 1'b1);

    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if ((k - 1) % DIV == 0) begin
        exp_sel = ~(6'b000001 << (((k - 1) / DIV) % 6));
        check("scan_step", sel6, exp_sel);
      end
    end

    offer(0, 16'd1234, {1'b0, D_1234}, 1'b1, 16'd5678);
    offer(0, 16'd5678, {1'b0, D_5678}, 1'b0, 16'd0);

    offer(1, 16'd12345, {1'b1, D_DASH4}, 1'b0, 16'd0);
    offer(1, 16'd42,    {1'b0, D_42},    1'b0, 16'd0);

    dp6 = 6'b000100;
    offer(0, 16'd7, {1'b0, D_7DP2}, 1'b0, 16'd0);
    dp6 = 6'b000000;
    offer(0, 16'd0, {1'b0, D_0}, 1'b0, 16'd0);

    // leave dut4 showing overflow so the reset below has something to clear
    offer(1, 16'd12345, {1'b1, D_DASH4}, 1'b0, 16'd0);

    // abort a conversion part-way through
    @(negedge clock);
    value6 = 16'd999; valid6 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid6 = 1'b0;
    repeat (4) @(negedge clock);
    check("midconv_busy", ready6, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready6", ready6, 1'b1);
    check("midrst_done6", done6, 1'b0);
    check("midrst_state6", st6, IDLE);
    check("midrst_sel6", sel6, 6'h3F);
    check("midrst_seg6", seg6, 8'hFF);
    check("midrst_ovf4", ovf4, 1'b0);
    @(negedge clock);
    rst_n = 1'b1;
    capture(0, segs, seen);
    check("midrst_seen", seen, 6'h3F);
    check("midrst_display_zero", {1'b0, segs}, {1'b0, D_0});

    offer(0, 16'd321, {1'b0, D_321}, 1'b0, 16'd0);

    repeat (4) @(negedge clock);
    check("exp6_q_drained", exp6_q.size(), 0);
    check("exp4_q_drained", exp4_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
